vending_machine_multi: RTL
==========================

// Module: vending_machine_multi
// PURPOSE
//   Parametrised successor to the single-price coin vending controller.
//   Accepts 1/2/5-rupee coins into a bounded credit register and sells one of
//   NUM_ITEMS products, each with its own price. After a sale, it returns change
//   as a sequence of coin pulses, one per cycle, largest coin first.
//   Sits between the coin acceptor and the dispenser/coin-hopper drivers.
// PARAMETERS
//   NUM_ITEMS   4                          number of selectable products (>=1)
//   SEL_W       2                          width of item_sel; 2**SEL_W >= NUM_ITEMS
//   CREDIT_W    5                          width of credit register and of each price
//   MAX_CREDIT  20                         highest credit accepted; < 2**CREDIT_W
//   PRICE_LIST  {5'd15,5'd12,5'd10,5'd7}   packed prices; item i = bits [i*CREDIT_W +: CREDIT_W]
// PORTS
//   clk         in   1         rising-edge clock
//   reset       in   1         asynchronous, active-low reset
//   rupee1      in   1         1-rupee coin present, sampled each clk
//   rupee2      in   1         2-rupee coin present
//   rupee5      in   1         5-rupee coin present
//   item_sel    in   SEL_W     product index, sampled with vend_req
//   vend_req    in   1         purchase request (level, sampled each clk)
//   cancel      in   1         refund request (only with VEND_CANCEL_EN)
//   dispense    out  1         1-cycle pulse: release product item_out
//   item_out    out  SEL_W     product index, valid while dispense=1
//   change1     out  1         1-cycle pulse: eject one 1-rupee coin
//   change2     out  1         1-cycle pulse: eject one 2-rupee coin
//   change5     out  1         1-cycle pulse: eject one 5-rupee coin
//   coin_reject out  1         1-cycle pulse: coin sampled this edge was refused
//   credit      out  CREDIT_W  current credit
//   state       out  2         FSM state: 0 IDLE, 1 CREDIT, 2 DISPENSE, 3 CHANGE
// BEHAVIOUR
//   Reset (reset=0, asynchronous): state=IDLE, credit=0, and all pulse outputs and item_out are 0.
//   All outputs are registered. A response appears in the cycle after the sampling edge.
//   IDLE/CREDIT, coin handling:
//     - Exactly one rupee input high: credit += value. State goes to CREDIT.
//     - Coin refused, coin_reject=1, credit unchanged, when any of:
//       two or more rupee inputs are high; credit+value > MAX_CREDIT;
//       vend_req or cancel is accepted on the same edge.
//   CREDIT, vend_req=1:
//     - item_sel >= NUM_ITEMS or credit < price: request ignored, no state change.
//     - Otherwise: move to DISPENSE; credit -= price; item_out <= item_sel.
//   DISPENSE (one cycle): dispense=1.
//     - Next state is CHANGE if credit>0, else IDLE.
//   CHANGE (one coin per cycle, greedy):
//     - credit>=5: change5, credit -= 5.
//     - Else credit>=2: change2, credit -= 2.
//     - Else: change1, credit -= 1.
//     - Go to IDLE in the cycle credit reaches 0.
//   DISPENSE/CHANGE: every coin is refused (coin_reject); vend_req and cancel are ignored.
//   Credit never exceeds MAX_CREDIT and never wraps. Arithmetic uses CREDIT_W+1 bits
//   for the overflow compare.
//   Reset mid-sale or mid-change aborts immediately; pending credit is discarded.
// CONFIGURATION
//   VEND_CANCEL_EN defined:
//     - cancel port present. In CREDIT, cancel=1 goes straight to CHANGE and returns
//       the full credit with no dispense.
//     - Priority on one edge: cancel > vend_req > coin.
//   VEND_CANCEL_EN undefined: cancel port absent; credit is returned only via change after a sale.
// TESTING
//   1. Reset low mid-run -> all outputs 0, state=0, within the same cycle (asynchronous).
//   2. rupee5, rupee2, then vend_req with item_sel=0 (price 7) -> dispense=1,
//      item_out=0; no change pulses; state back to 0.
//   3. rupee5 x2, vend item 0 -> dispense, then change2, then change1 on
//      consecutive cycles; credit 3 -> 1 -> 0.
//   4. Credit 20, insert rupee1 -> coin_reject=1, credit stays 20.
//      rupee1 and rupee2 together -> coin_reject=1, credit unchanged.
//   5. Credit 7, vend item 3 (price 15), and separately item_sel out of range
//      -> no dispense, credit stays 7, state stays 1.
//   6. [VEND_CANCEL_EN] credit 8, cancel -> change5, change2, change1, then IDLE;
//      no dispense. Coin inserted during CHANGE -> coin_reject.

Source files
------------

// File: rtl/vending_machine_multi.sv
// Multi-product coin vending controller: bounded credit, per-item prices, greedy coin change.
// Optional refund path enabled by defining VEND_CANCEL_EN (adds the cancel port).
`timescale 1ns/1ps
module vending_machine_multi #(
   parameter int NUM_ITEMS  = 4,
   parameter int SEL_W      = 2,
   parameter int CREDIT_W   = 5,
   parameter int MAX_CREDIT = 20,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {5'd15, 5'd12, 5'd10, 5'd7}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rupee1,
   input  logic                rupee2,
   input  logic                rupee5,
   input  logic [SEL_W-1:0]    item_sel,
   input  logic                vend_req,
`ifdef VEND_CANCEL_EN
   input  logic                cancel,
`endif
   output logic                dispense,
   output logic [SEL_W-1:0]    item_out,
   output logic                change1,
   output logic                change2,
   output logic                change5,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          state
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CREDIT   = 2'd1,
      S_DISPENSE = 2'd2,
      S_CHANGE   = 2'd3
   } state_t;

   localparam logic [CREDIT_W:0]   LP_MAX = MAX_CREDIT[CREDIT_W:0];
   localparam logic [CREDIT_W:0]   LP_V1  = (CREDIT_W+1)'(1);
   localparam logic [CREDIT_W:0]   LP_V2  = (CREDIT_W+1)'(2);
   localparam logic [CREDIT_W:0]   LP_V5  = (CREDIT_W+1)'(5);
   localparam logic [CREDIT_W-1:0] LP_C1  = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] LP_C2  = CREDIT_W'(2);
   localparam logic [CREDIT_W-1:0] LP_C5  = CREDIT_W'(5);

   state_t              r_state, w_nxt_state;
   logic [CREDIT_W-1:0] r_credit, w_nxt_credit;
   logic [SEL_W-1:0]    r_item_out, w_nxt_item_out;
   logic                r_dispense, w_nxt_dispense;
   logic                r_change1, w_nxt_change1;
   logic                r_change2, w_nxt_change2;
   logic                r_change5, w_nxt_change5;
   logic                r_coin_reject, w_nxt_coin_reject;

   logic                w_cancel;
   logic                w_any_coin;
   logic                w_one_coin;
   logic [CREDIT_W:0]   w_coin_val;
   logic [CREDIT_W:0]   w_sum;
   logic [31:0]         w_sel_ext;
   logic                w_sel_ok;
   logic [CREDIT_W-1:0] w_price;

`ifdef VEND_CANCEL_EN
   assign w_cancel = cancel;
`else
   assign w_cancel = 1'b0;
`endif

   assign w_any_coin = rupee1 | rupee2 | rupee5;
   assign w_one_coin = (rupee1 ^ rupee2 ^ rupee5) & ~(rupee1 & rupee2 & rupee5);
   assign w_coin_val = rupee5 ? LP_V5 : (rupee2 ? LP_V2 : LP_V1);
   // One extra bit so the overflow compare cannot wrap.
   assign w_sum      = {1'b0, r_credit} + w_coin_val;
   assign w_sel_ext  = 32'(item_sel);

   always_comb begin
      w_sel_ok = 1'b0;
      w_price  = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (w_sel_ext == i) begin
            w_sel_ok = 1'b1;
            w_price  = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
         end
      end
   end

   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_credit      = r_credit;
      w_nxt_item_out    = r_item_out;
      w_nxt_dispense    = 1'b0;
      w_nxt_change1     = 1'b0;
      w_nxt_change2     = 1'b0;
      w_nxt_change5     = 1'b0;
      w_nxt_coin_reject = 1'b0;
      case (r_state)
         S_IDLE, S_CREDIT: begin
            // Priority on one edge: cancel, then a valid sale, then the coin.
            if (r_state == S_CREDIT && w_cancel) begin
               w_nxt_state       = S_CHANGE;
               w_nxt_coin_reject = w_any_coin;
            end else if (r_state == S_CREDIT && vend_req && w_sel_ok && r_credit >= w_price) begin
               w_nxt_state       = S_DISPENSE;
               w_nxt_credit      = r_credit - w_price;
               w_nxt_item_out    = item_sel;
               w_nxt_dispense    = 1'b1;
               w_nxt_coin_reject = w_any_coin;
            end else if (w_any_coin) begin
               if (w_one_coin && w_sum <= LP_MAX) begin
                  w_nxt_credit = w_sum[CREDIT_W-1:0];
                  w_nxt_state  = S_CREDIT;
               end else begin
                  w_nxt_coin_reject = 1'b1;
               end
            end
         end
         S_DISPENSE: begin
            w_nxt_coin_reject = w_any_coin;
            w_nxt_state       = (r_credit != '0) ? S_CHANGE : S_IDLE;
         end
         S_CHANGE: begin
            w_nxt_coin_reject = w_any_coin;
            if (r_credit >= LP_C5) begin
               w_nxt_change5 = 1'b1;
               w_nxt_credit  = r_credit - LP_C5;
            end else if (r_credit >= LP_C2) begin
               w_nxt_change2 = 1'b1;
               w_nxt_credit  = r_credit - LP_C2;
            end else if (r_credit != '0) begin
               w_nxt_change1 = 1'b1;
               w_nxt_credit  = r_credit - LP_C1;
            end
            if (w_nxt_credit == '0) w_nxt_state = S_IDLE;
         end
         default: w_nxt_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_credit      <= '0;
         r_item_out    <= '0;
         r_dispense    <= 1'b0;
         r_change1     <= 1'b0;
         r_change2     <= 1'b0;
         r_change5     <= 1'b0;
         r_coin_reject <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_credit      <= w_nxt_credit;
         r_item_out    <= w_nxt_item_out;
         r_dispense    <= w_nxt_dispense;
         r_change1     <= w_nxt_change1;
         r_change2     <= w_nxt_change2;
         r_change5     <= w_nxt_change5;
         r_coin_reject <= w_nxt_coin_reject;
      end
   end

   assign dispense    = r_dispense;
   assign item_out    = r_item_out;
   assign change1     = r_change1;
   assign change2     = r_change2;
   assign change5     = r_change5;
   assign coin_reject = r_coin_reject;
   assign credit      = r_credit;
   assign state       = r_state;

endmodule
